// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control word that MEM/WB loads while the controller bubbles it.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } memwb_ctrl_t;

    localparam memwb_ctrl_t MEMWB_NOP = '{regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage controller.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic              memtoreg;
    logic              memwrite;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] readdata;
    logic              stall;
    logic              bubble;
    logic              bus_error;

    modport master (
        input  memtoreg, memwrite, aluout, writedata, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, readdata, stall, bubble, bus_error
    );

    modport slave (
        output memtoreg, memwrite, aluout, writedata, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, readdata, stall, bubble, bus_error
    );

endinterface

// File: rtl/mem_access_ctrl_watchdog.sv
// Saturating BUSY-cycle counter that raises terminal once TIMEOUT-1 is reached.
module mem_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Holding at LAST keeps the count from ever wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores against a req/ack data memory, stalling the pipeline meanwhile.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);

    state_t            state_q, state_d;
    logic              memop;
    logic              wd_clear, wd_enable, wd_term;
    logic              req_q, we_q, err_q;
    logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;

    assign memop = bus.memtoreg | bus.memwrite;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .terminal (wd_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d  = BUSY;
                    wd_clear = 1'b1;
                end
            end
            BUSY: begin
                if (bus.dmem_ack || wd_term) begin
                    state_d = DONE;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous load+store flag is issued as a store because we follows memwrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memop) begin
                        addr_q  <= bus.aluout;
                        wdata_q <= bus.writedata;
                        we_q    <= bus.memwrite;
                        req_q   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.dmem_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus.dmem_rdata;
                        end
                        req_q <= 1'b0;
                    end else if (wd_term) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stall      = ((state_q == IDLE) && memop) || (state_q == BUSY);
    assign bus.bubble     = bus.stall;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.readdata   = rdata_q;
    assign bus.bus_error  = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a randomized transaction model.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] aluout;
        logic [31:0] wdata;
        logic [2:0]  eFlags;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eRd;
        logic        eErr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t vecs [20];

    logic [31:0] mAddr, mWdata, mRd;
    logic        mWe, mErr;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] rdata, input logic [31:0] aluout,
                                input logic [31:0] wdata, input logic [2:0] eFlags, input logic [31:0] eAddr,
                                input logic [31:0] eWdata, input logic [31:0] eRd, input logic eErr);
        vec_t v;
        v.ctl = ctl; v.rdata = rdata; v.aluout = aluout; v.wdata = wdata;
        v.eFlags = eFlags; v.eAddr = eAddr; v.eWdata = eWdata; v.eRd = eRd; v.eErr = eErr;
        return v;
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic mr, input logic mw, input logic ack, input logic [31:0] rdata,
                                 input logic [31:0] aluout, input logic [31:0] wdata);
        bus.memtoreg   = mr;
        bus.memwrite   = mw;
        bus.dmem_ack   = ack;
        bus.dmem_rdata = rdata;
        bus.aluout     = aluout;
        bus.writedata  = wdata;
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eStall, input logic eReq, input logic eWe,
                            input logic [31:0] eAddr, input logic [31:0] eWdata, input logic [31:0] eRd,
                            input logic eErr);
        checkOutput({tag, " stall"},     32'(bus.stall),     32'(eStall));
        checkOutput({tag, " bubble"},    32'(bus.bubble),    32'(eStall));
        checkOutput({tag, " req"},       32'(bus.dmem_req),  32'(eReq));
        checkOutput({tag, " we"},        32'(bus.dmem_we),   32'(eWe));
        checkOutput({tag, " addr"},      bus.dmem_addr,      eAddr);
        checkOutput({tag, " wdata"},     bus.dmem_wdata,     eWdata);
        checkOutput({tag, " readdata"},  bus.readdata,       eRd);
        checkOutput({tag, " bus_error"}, 32'(bus.bus_error), 32'(eErr));
    endtask

    initial begin
        logic [31:0] addr, wd, rd;
        logic        mr, mw;
        int          kind, delay, busyLen;

        // {memtoreg,memwrite,ack}, rdata, aluout, writedata, {stall,req,we}, addr, wdata, readdata, bus_error
        vecs[0]  = mk(3'b100, 32'h0,        32'h100, 32'h0,        3'b100, 32'h0,   32'h0,        32'h0,        1'b0);
        vecs[1]  = mk(3'b100, 32'h0,        32'h100, 32'h0,        3'b110, 32'h100, 32'h0,        32'h0,        1'b0);
        vecs[2]  = mk(3'b100, 32'h0,        32'h100, 32'h0,        3'b110, 32'h100, 32'h0,        32'h0,        1'b0);
        vecs[3]  = mk(3'b101, 32'hDEADBEEF, 32'h100, 32'h0,        3'b110, 32'h100, 32'h0,        32'h0,        1'b0);
        vecs[4]  = mk(3'b100, 32'h0,        32'h100, 32'h0,        3'b000, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[5]  = mk(3'b010, 32'h0,        32'h200, 32'h1234,     3'b100, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[6]  = mk(3'b011, 32'h55555555, 32'h200, 32'h1234,     3'b111, 32'h200, 32'h1234,     32'hDEADBEEF, 1'b0);
        vecs[7]  = mk(3'b010, 32'h0,        32'h200, 32'h1234,     3'b001, 32'h200, 32'h1234,     32'hDEADBEEF, 1'b0);
        vecs[8]  = mk(3'b100, 32'h0,        32'h10,  32'hAAAA0000, 3'b101, 32'h200, 32'h1234,     32'hDEADBEEF, 1'b0);
        vecs[9]  = mk(3'b101, 32'hCAFEF00D, 32'h10,  32'hAAAA0000, 3'b110, 32'h10,  32'hAAAA0000, 32'hDEADBEEF, 1'b0);
        vecs[10] = mk(3'b100, 32'h0,        32'h10,  32'hAAAA0000, 3'b000, 32'h10,  32'hAAAA0000, 32'hCAFEF00D, 1'b0);
        vecs[11] = mk(3'b010, 32'h0,        32'h14,  32'h77,       3'b100, 32'h10,  32'hAAAA0000, 32'hCAFEF00D, 1'b0);
        vecs[12] = mk(3'b011, 32'h0,        32'h14,  32'h77,       3'b111, 32'h14,  32'h77,       32'hCAFEF00D, 1'b0);
        vecs[13] = mk(3'b010, 32'h0,        32'h14,  32'h77,       3'b001, 32'h14,  32'h77,       32'hCAFEF00D, 1'b0);
        vecs[14] = mk(3'b001, 32'hFFFFFFFF, 32'h0,   32'h0,        3'b001, 32'h14,  32'h77,       32'hCAFEF00D, 1'b0);
        vecs[15] = mk(3'b000, 32'h0,        32'h0,   32'h0,        3'b001, 32'h14,  32'h77,       32'hCAFEF00D, 1'b0);
        vecs[16] = mk(3'b110, 32'h0,        32'h20,  32'h99,       3'b101, 32'h14,  32'h77,       32'hCAFEF00D, 1'b0);
        vecs[17] = mk(3'b111, 32'h12345678, 32'h20,  32'h99,       3'b111, 32'h20,  32'h99,       32'hCAFEF00D, 1'b0);
        vecs[18] = mk(3'b110, 32'h0,        32'h20,  32'h99,       3'b001, 32'h20,  32'h99,       32'hCAFEF00D, 1'b0);
        vecs[19] = mk(3'b000, 32'h0,        32'h0,   32'h0,        3'b001, 32'h20,  32'h99,       32'hCAFEF00D, 1'b0);

        bus.memtoreg = 1'b0; bus.memwrite = 1'b0; bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0; bus.aluout = '0; bus.writedata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        nextCycle();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].rdata, vecs[i].aluout, vecs[i].wdata);
            checkAll($sformatf("vec%0d", i), vecs[i].eFlags[2], vecs[i].eFlags[1], vecs[i].eFlags[0],
                     vecs[i].eAddr, vecs[i].eWdata, vecs[i].eRd, vecs[i].eErr);
            nextCycle();
        end

        // Non-memory instructions with stray acks must leave everything untouched.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
            checkAll("idle-ack", 1'b0, 1'b0, 1'b1, 32'h20, 32'h99, 32'hCAFEF00D, 1'b0);
            nextCycle();
        end

        $display("[TB] watchdog timeout sequence");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0);
        checkOutput("to idle stall", 32'(bus.stall), 32'd1);
        nextCycle();
        for (int j = 1; j <= TIMEOUT; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0);
            checkOutput($sformatf("to busy%0d req", j), 32'(bus.dmem_req), 32'd1);
            checkOutput($sformatf("to busy%0d addr", j), bus.dmem_addr, 32'h300);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0);
        checkOutput("to done req", 32'(bus.dmem_req), 32'd0);
        checkOutput("to done stall", 32'(bus.stall), 32'd0);
        checkOutput("to done bus_error", 32'(bus.bus_error), 32'd1);
        checkOutput("to done readdata", bus.readdata, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("to resume stall", 32'(bus.stall), 32'd0);
        checkOutput("to resume bus_error", 32'(bus.bus_error), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0);
        checkOutput("to next idle stall", 32'(bus.stall), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hBEEF0001, 32'h40, 32'h0);
        checkOutput("to next busy req", 32'(bus.dmem_req), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0);
        checkOutput("to next done readdata", bus.readdata, 32'hBEEF0001);
        checkOutput("to next done bus_error", 32'(bus.bus_error), 32'd1);
        checkOutput("to next done stall", 32'(bus.stall), 32'd0);
        nextCycle();

        $display("[TB] reset during BUSY sequence");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h500, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h500, 32'h0);
        checkOutput("rst busy1 req", 32'(bus.dmem_req), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h500, 32'h0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hBAD0BAD0, 32'h0, 32'h0);
        checkAll("rst after", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hBAD0BAD0, 32'h0, 32'h0);
        checkAll("rst late-ack", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        nextCycle();

        // Randomized transactions against a per-access expectation model.
        mAddr = '0; mWdata = '0; mRd = '0; mWe = 1'b0; mErr = 1'b0;
        for (int t = 0; t < 40; t++) begin
            kind  = int'($urandom_range(0, 3));
            addr  = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            delay = int'($urandom_range(1, TIMEOUT + 2));
            if (kind == 0) begin
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, addr, wd);
                checkAll("rnd nonmem", 1'b0, 1'b0, mWe, mAddr, mWdata, mRd, mErr);
                nextCycle();
            end else begin
                mr = (kind != 2);
                mw = (kind != 1);
                applyStimulus(mr, mw, 1'($urandom_range(0, 1)), $urandom, addr, wd);
                checkAll("rnd issue", 1'b1, 1'b0, mWe, mAddr, mWdata, mRd, mErr);
                nextCycle();
                mAddr = addr; mWdata = wd; mWe = mw;
                busyLen = (delay <= TIMEOUT) ? delay : TIMEOUT;
                for (int j = 1; j <= busyLen; j++) begin
                    applyStimulus(mr, mw, (j == delay), rd, $urandom, $urandom);
                    checkAll("rnd busy", 1'b1, 1'b1, mWe, mAddr, mWdata, mRd, mErr);
                    nextCycle();
                end
                if (delay <= TIMEOUT) begin
                    if (!mw) mRd = rd;
                end else begin
                    mRd  = '0;
                    mErr = 1'b1;
                end
                applyStimulus(mr, mw, 1'($urandom_range(0, 1)), $urandom, addr, wd);
                checkAll("rnd done", 1'b0, 1'b0, mWe, mAddr, mWdata, mRd, mErr);
                nextCycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MEM stage of the 5-stage MIPS pipeline against a variable-latency data memory using a req/ack handshake.
- While an access is outstanding, it freezes the upstream stage registers (PC, IF/ID, ID/EX, EX/MEM) and feeds bubbles into MEM/WB.
- When the access completes, it returns load data and releases the pipeline. A watchdog flags a hung bus.

Parameters:
- TIMEOUT, 64, max BUSY cycles without dmem_ack before abort (1..65535).
- CNT_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- memtoreg  in  1  MEM-stage instruction is a load (from EX/MEM register)
- memwrite  in  1  MEM-stage instruction is a store (from EX/MEM register)
- aluout  in  32  MEM-stage effective address
- writedata  in  32  MEM-stage store data
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  latched address
- dmem_wdata  out  32  latched store data
- dmem_rdata  in  32  memory read data, valid with dmem_ack
- dmem_ack  in  1  memory completion strobe
- readdata  out  32  load data to MEM/WB, valid in DONE
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- bubble  out  1  MEM/WB loads a nop (regwrite=0, memtoreg=0)
- bus_error  out  1  sticky watchdog-abort flag

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- memop = memtoreg | memwrite. If both are 1, treat the access as a store.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If memop: latch aluout, writedata and memwrite into dmem_addr, dmem_wdata and dmem_we; set dmem_req=1; clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - dmem_req stays 1. addr, we and wdata stay stable.
  - If dmem_ack: capture dmem_rdata into readdata (loads only; stores leave readdata unchanged); drop dmem_req; go to DONE.
  - Else if counter == TIMEOUT-1: set bus_error=1; readdata=0; drop dmem_req; go to DONE.
  - Else increment the counter.
- DONE:
  - Always returns to IDLE next cycle.
  - An instruction that reaches MEM after DONE starts its own access from IDLE. There is no re-issue of the completed access, because EX/MEM advances at the end of DONE.
- stall (combinational) = (state==IDLE & memop) | state==BUSY. stall is 0 in DONE.
- bubble = stall. MEM/WB captures real control and readdata only in DONE or for non-memory instructions.
- dmem_ack outside BUSY is ignored.
- Latency: an ack in BUSY cycle n puts DONE at n+1. Minimum access is 3 cycles (IDLE-detect, BUSY with ack, DONE). Non-memory instructions add 0 cycles.
- Back-to-back memory ops: DONE→IDLE→BUSY. Stall resumes in that IDLE cycle.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, readdata=0, bus_error=0, counter=0.
- Reset mid-BUSY drops dmem_req in the next cycle. A late ack is then ignored.
- bus_error clears only on reset. Later accesses proceed normally.
- Counter saturates; it never wraps within BUSY.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - nop control constants for the MEM/WB bubble
- One natural sub-module, mem_watchdog: a CNT_W counter with clear, enable and a terminal flag (== TIMEOUT-1).
- The FSM, latches and stall logic stay in mem_access_ctrl.

Test Plan:
- Load, ack on the 3rd BUSY cycle. aluout=0x100, memtoreg=1, dmem_rdata=0xDEADBEEF.
  - dmem_req high for 3 cycles; dmem_addr=0x100; dmem_we=0.
  - stall high for 4 cycles; readdata=0xDEADBEEF in DONE; stall=0 in DONE.
- Store, ack on the 1st BUSY cycle. memwrite=1, aluout=0x200, writedata=0x1234.
  - dmem_we=1, dmem_wdata=0x1234; req high for 1 cycle; stall high for 2 cycles; readdata unchanged.
- Back-to-back load then store, each acked immediately.
  - Two distinct requests (addr 0x10, then 0x14); no duplicate request for 0x10; the IDLE cycle between them has stall=1.
- TIMEOUT=4, no ack.
  - req drops after 4 BUSY cycles; bus_error=1 sticky; readdata=0; pipeline resumes.
  - A following load with ack completes normally; bus_error is still 1.
- reset asserted on the 2nd BUSY cycle.
  - Next cycle: dmem_req=0, stall=0 (if memop=0), state=IDLE.
  - A late ack has no effect; readdata=0.
- memop=0 for 10 cycles with random acks.
  - dmem_req never asserts; stall=0 and bubble=0 throughout.
